// File: rtl/giaima_7doan_pkg.sv
// Shared constants and the hex-to-7-segment decode for the digit scanner.
package giaima_7doan_pkg;

  localparam logic [7:0] SSEG_BLANK = 8'h00;
  localparam int         GHOST_CYC  = 2;

  // Segment order {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] hex7(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/giaima_7doan_lut.sv
// Combinational digit decode: hex glyph gated by ena_i, decimal point passed through.
module giaima_7doan_lut
  import giaima_7doan_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       ena_i,
  input  logic       dp_i,
  output logic [7:0] sseg_o
);

  assign sseg_o = {dp_i, ena_i ? hex7(code_i) : SSEG_BLANK[6:0]};

endmodule

// File: rtl/giaima_7doan_quet.sv
// Time-multiplexed N-digit hex 7-segment scanner with per-frame input snapshot
// and leading-zero suppression. Define GIAIMA_QUET_GHOST_BLANK_EN for anti-ghost gaps.
module giaima_7doan_quet
  import giaima_7doan_pkg::*;
#(
  parameter int N_DIGIT       = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*N_DIGIT-1:0] so_gma,
  input  logic [N_DIGIT-1:0]   ena,
  input  logic [N_DIGIT-1:0]   dp,
  input  logic                 lz_en,
  output logic [7:0]           sseg,
  output logic [N_DIGIT-1:0]   an,
  output logic                 frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(N_DIGIT - 1);
  localparam logic [N_DIGIT-1:0] AN_ONE  = N_DIGIT'(1);
  localparam logic [N_DIGIT-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGIT{1'b1}} : '0;

`ifdef GIAIMA_QUET_GHOST_BLANK_EN
  if (SCAN_DIV < 4) begin : g_scan_div_chk
    $error("giaima_7doan_quet: SCAN_DIV must be >= 4 with ghost blanking");
  end
`endif

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*N_DIGIT-1:0] code_s_q;
  logic [N_DIGIT-1:0]   ena_s_q, dp_s_q;
  logic                 lz_s_q;
  logic [N_DIGIT-1:0]   an_q, an_d;
  logic [7:0]           sseg_q, sseg_d;
  logic                 fs_q, fs_d;

  logic                 slot_end, frame_end;
  logic [3:0]           code_sel;
  logic                 ena_sel, dp_sel, supp, blank;
  logic [7:0]           sseg_lut;
  logic [N_DIGIT-1:0]   an_sel;

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);
  assign cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
  assign idx_d     = slot_end ? ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1) : idx_q;

  // Select the active digit and decide whether it is a suppressed leading zero
  always_comb begin
    code_sel = 4'h0;
    ena_sel  = 1'b0;
    dp_sel   = 1'b0;
    supp     = lz_s_q && (idx_q != '0);
    for (int j = 0; j < N_DIGIT; j++) begin
      if (idx_q == IDX_W'(j)) begin
        code_sel = code_s_q[4*j +: 4];
        ena_sel  = ena_s_q[j];
        dp_sel   = dp_s_q[j];
      end
      if ((IDX_W'(j) >= idx_q) && ena_s_q[j] && (code_s_q[4*j +: 4] != 4'h0))
        supp = 1'b0;
    end
  end

  giaima_7doan_lut u_lut (
    .code_i (code_sel),
    .ena_i  (ena_sel & ~supp),
    .dp_i   (dp_sel & ena_sel),
    .sseg_o (sseg_lut)
  );

`ifdef GIAIMA_QUET_GHOST_BLANK_EN
  assign blank = (cnt_q < CNT_W'(GHOST_CYC));
`else
  assign blank = 1'b0;
`endif

  assign an_sel = AN_ONE << idx_q;
  assign an_d   = blank ? AN_OFF : ((AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel);
  assign sseg_d = blank ? SSEG_BLANK : sseg_lut;
  assign fs_d   = (idx_q == '0) && (cnt_q == '0);

  // Prescaler, snapshot and output registers; outputs lag idx by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      code_s_q <= '0;
      ena_s_q  <= '0;
      dp_s_q   <= '0;
      lz_s_q   <= 1'b0;
      an_q     <= AN_OFF;
      sseg_q   <= SSEG_BLANK;
      fs_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      fs_q   <= fs_d;
      if (frame_end) begin
        code_s_q <= so_gma;
        ena_s_q  <= ena;
        dp_s_q   <= dp;
        lz_s_q   <= lz_en;
      end
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = fs_q;

endmodule
